// File: rtl/reg_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_pkg : shared CPU constants, register indices, WB controls   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package reg_file_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int ADDR_WIDTH        = 5;
    localparam int WRITE_COUNT_WIDTH = 16;

    localparam int ZERO = 0;
    localparam int RA   = 31;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC4 = 2'd2
    } wb_src_e;

    // Control bits carried down to the write-back stage.
    typedef struct packed {
        logic    reg_write;
        wb_src_e wb_src;
        logic    link;
    } wb_ctrl_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_if : write-back and read-port bundle for the register file  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
);
    logic                         iRegWrite;
    logic [ADDR_WIDTH-1:0]        iRegAddress;
    logic [DATA_WIDTH-1:0]        iRegData;
    logic [ADDR_WIDTH-1:0]        iReadAddr1;
    logic [ADDR_WIDTH-1:0]        iReadAddr2;
    logic [ADDR_WIDTH-1:0]        iDebugAddr;
    logic [DATA_WIDTH-1:0]        oReadData1;
    logic [DATA_WIDTH-1:0]        oReadData2;
    logic [DATA_WIDTH-1:0]        oDebugData;
    logic [WRITE_COUNT_WIDTH-1:0] oWriteCount;

    modport master (
        output iRegWrite, iRegAddress, iRegData,
        output iReadAddr1, iReadAddr2, iDebugAddr,
        input  oReadData1, oReadData2, oDebugData, oWriteCount
    );

    modport slave (
        input  iRegWrite, iRegAddress, iRegData,
        input  iReadAddr1, iReadAddr2, iDebugAddr,
        output oReadData1, oReadData2, oDebugData, oWriteCount
    );

endinterface : reg_file_if
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_read_port : one combinational read port with optional bypass     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
    input  wire logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  wire logic                  wr_en_i,
    input  wire logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  wire logic [DATA_WIDTH-1:0] wr_data_i,
    input  wire logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
    output logic      [DATA_WIDTH-1:0] data_o
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO);

    logic [DATA_WIDTH-1:0] stored;

    assign stored = (rd_addr_i == ZERO_IDX) ? '0 : regs_i[rd_addr_i];

    generate
        if (BYPASS) begin : g_bypass
            // wr_en_i is already qualified (non-zero index, not in reset).
            assign data_o = (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : stored;
        end else begin : g_no_bypass
            logic unused_bypass_inputs;
            assign unused_bypass_inputs = ^{wr_en_i, wr_addr_i, wr_data_i};
            assign data_o = stored;
        end
    endgenerate

endmodule : reg_read_port
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file : 2**ADDR_WIDTH x DATA_WIDTH register file, r0 hard-wired 0 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    reg_file_if.slave  bus
);

    localparam int                    NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO);

    logic [DATA_WIDTH-1:0]        regs_q [NUM_REGS];
    logic [WRITE_COUNT_WIDTH-1:0] wr_count_q;
    logic [WRITE_COUNT_WIDTH-1:0] wr_count_d;
    logic                         commit;

    // Reset masks the write so it neither commits nor feeds the bypass path.
    assign commit     = bus.iRegWrite && (bus.iRegAddress != ZERO_IDX) && !reset;
    assign wr_count_d = wr_count_q + WRITE_COUNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (commit) begin
            regs_q[bus.iRegAddress] <= bus.iRegData;
            wr_count_q              <= wr_count_d;
        end
    end

    assign bus.oWriteCount = wr_count_q;

    reg_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS(BYPASS)) u_rd1 (
        .rd_addr_i (bus.iReadAddr1),
        .wr_en_i   (commit),
        .wr_addr_i (bus.iRegAddress),
        .wr_data_i (bus.iRegData),
        .regs_i    (regs_q),
        .data_o    (bus.oReadData1)
    );

    reg_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS(BYPASS)) u_rd2 (
        .rd_addr_i (bus.iReadAddr2),
        .wr_en_i   (commit),
        .wr_addr_i (bus.iRegAddress),
        .wr_data_i (bus.iRegData),
        .regs_i    (regs_q),
        .data_o    (bus.oReadData2)
    );

    reg_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS(1'b0)) u_dbg (
        .rd_addr_i (bus.iDebugAddr),
        .wr_en_i   (commit),
        .wr_addr_i (bus.iRegAddress),
        .wr_data_i (bus.iRegData),
        .regs_i    (regs_q),
        .data_o    (bus.oDebugData)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file : directed scoreboard bench for reg_file                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_if bus ();

    reg_file #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb [$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mdl [32];

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%h expected=<none>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        bus.iRegWrite   = we;
        bus.iRegAddress = wa;
        bus.iRegData    = wd;
        bus.iReadAddr1  = r1;
        bus.iReadAddr2  = r2;
        bus.iDebugAddr  = dbg;
    endtask

    task automatic pop_ports();
        pop_check(bus.oReadData1);
        pop_check(bus.oReadData2);
        pop_check(bus.oDebugData);
    endtask

    task automatic pop_count();
        pop_check({16'h0, bus.oWriteCount});
    endtask

    initial begin
        int          a;
        logic [31:0] d;

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;

        // Every index reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i));
            push("rst_rd1", 32'h0);
            push("rst_rd2", 32'h0);
            push("rst_dbg", 32'h0);
            push("rst_cnt", 32'h0);
            #2;
            pop_ports();
            pop_count();
            tick();
        end

        // Same-cycle bypass on port 1; debug sees stored value only.
        drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd9, 5'd8);
        push("byp_rd1", 32'hDEADBEEF);
        push("byp_rd2_other", 32'h0);
        push("byp_dbg_nobyp", 32'h0);
        #2;
        pop_ports();
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
        push("r8_rd1", 32'hDEADBEEF);
        push("r8_rd2", 32'hDEADBEEF);
        push("r8_dbg", 32'hDEADBEEF);
        push("r8_cnt", 32'd1);
        #2;
        pop_ports();
        pop_count();
        tick();

        // Writes to r0 are dropped and not counted.
        drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
        push("r0w_rd1", 32'h0);
        push("r0w_rd2", 32'h0);
        push("r0w_dbg", 32'h0);
        push("r0w_cnt", 32'd1);
        #2;
        pop_ports();
        pop_count();
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        push("r0_rd1", 32'h0);
        push("r0_rd2", 32'h0);
        push("r0_dbg", 32'h0);
        push("r0_cnt", 32'd1);
        #2;
        pop_ports();
        pop_count();
        tick();

        // jal link write to RA, both ports bypass together.
        drive(1'b1, 5'(RA), 32'h00400004, 5'(RA), 5'(RA), 5'd8);
        push("ra_byp_rd1", 32'h00400004);
        push("ra_byp_rd2", 32'h00400004);
        push("ra_byp_dbg_r8", 32'hDEADBEEF);
        #2;
        pop_ports();
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'(RA), 5'(RA), 5'(RA));
        push("ra_rd1", 32'h00400004);
        push("ra_rd2", 32'h00400004);
        push("ra_dbg", 32'h00400004);
        push("ra_cnt", 32'd2);
        #2;
        pop_ports();
        pop_count();
        tick();

        // Reset beats a simultaneous write, and suppresses bypass meanwhile.
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'hFFFFFFFF, 5'd5, 5'd8, 5'(RA));
        push("rstw_rd1_nobyp", 32'h0);
        push("rstw_rd2_r8", 32'hDEADBEEF);
        push("rstw_dbg_ra", 32'h00400004);
        #2;
        pop_ports();
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd8, 5'(RA));
        push("post_rst_r5", 32'h0);
        push("post_rst_r8", 32'h0);
        push("post_rst_ra", 32'h0);
        push("post_rst_cnt", 32'h0);
        #2;
        pop_ports();
        pop_count();
        tick();

        // 65536 committed writes: counter wraps, contents follow the model.
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int n = 0; n < 65536; n++) begin
            a = int'($urandom_range(31, 1));
            d = $urandom;
            drive(1'b1, 5'(a), d, 5'(a), 5'd0, 5'd0);
            mdl[a] = d;
            if (n == 0 || n == 65535) begin
                push("wrap_cnt_before", 32'(n));
                #2;
                pop_count();
            end
            if ((n % 8192) == 7) begin
                push("loop_byp_rd1", d);
                push("loop_rd2_r0", 32'h0);
                #2;
                pop_check(bus.oReadData1);
                pop_check(bus.oReadData2);
            end
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        push("wrap_cnt", 32'h0);
        #2;
        pop_count();

        for (int i = 0; i < 32; i++) begin
            tick();
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i));
            push("final_rd1", mdl[i]);
            push("final_rd2", mdl[i]);
            push("final_dbg", mdl[i]);
            #2;
            pop_ports();
        end

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL expose parameters (name, default, meaning): DATA_WIDTH, 32, register width; ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers); BYPASS, 1, enables same-cycle write-to-read forwarding.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; ports are listed below as name, direction, width, meaning.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iRegWrite  input  1  write enable from the write-back stage.
REQ-006 iRegAddress  input  ADDR_WIDTH  write destination index.
REQ-007 iRegData  input  DATA_WIDTH  write data (ALU result, load data or PC+4, already selected upstream).
REQ-008 iReadAddr1 / iReadAddr2  input  ADDR_WIDTH each  rs / rt read indices from decode.
REQ-009 oReadData1 / oReadData2  output  DATA_WIDTH each  rs / rt read data.
REQ-010 iDebugAddr  input  ADDR_WIDTH  third read index for debug/display.
REQ-011 oDebugData  output  DATA_WIDTH  debug read data; never bypassed.
REQ-012 oWriteCount  output  16  count of committed writes since reset.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH flop registers of DATA_WIDTH bits, updated only on the rising edge of clk.
REQ-014 A write SHALL commit when iRegWrite=1 and iRegAddress!=0, with iRegData stored at iRegAddress at that edge.
REQ-015 Register 0 SHALL read as zero on every port; writes to index 0 SHALL be discarded and SHALL NOT increment oWriteCount.
REQ-016 Reads SHALL be combinational, with zero-cycle latency from the address to the data.
REQ-017 With BYPASS=1, the following SHALL hold for oReadData1/2: when iRegWrite=1, iRegAddress!=0 and iRegAddress equals the read index, the port SHALL return iRegData in the same cycle.
REQ-018 With BYPASS=0, reads SHALL return stored contents only, so new data becomes visible in the cycle after the write edge.
REQ-019 oDebugData SHALL always return stored contents (index 0 returns 0).
REQ-020 Both read ports addressing the same register SHALL return identical values.
REQ-021 oWriteCount SHALL increment by 1 on each committed write and SHALL wrap from 16'hFFFF to 0.
REQ-022 If reset and iRegWrite are both asserted in a cycle, reset SHALL win: all registers are 0 after the edge and the count is 0.
REQ-023 While reset is asserted, bypass SHALL be suppressed, so read ports return stored contents.

Reset
REQ-024 On a clk edge with reset=1, all registers SHALL clear to 0 and oWriteCount SHALL clear to 0.
REQ-025 Immediately after reset, every read port SHALL output 0, unless a bypass is active on that port in the following cycle.
REQ-026 A reset asserted mid-operation SHALL discard all committed contents; no write is partially retained.

Structure
REQ-027 DATA_WIDTH, ADDR_WIDTH and the register-index constants (ZERO=0, RA=31) SHALL live in the shared CPU package, alongside the control-signal bit-field definitions used by the write-back stage.
REQ-028 One sub-module, reg_read_port, SHALL implement a single read port (index compare, zero-force, optional bypass mux) and SHALL be instantiated three times, with bypass disabled for the debug instance.

Verification
REQ-029 The bench SHALL cover: reset, then read indices 0..31 on all ports -> all read 0 and oWriteCount=0.
REQ-030 The bench SHALL cover: write 0xDEADBEEF to r8 while reading r8 on port 1 in the same cycle, BYPASS=1 -> oReadData1=0xDEADBEEF that cycle, oDebugData(r8)=0 that cycle, oDebugData(r8)=0xDEADBEEF the next cycle.
REQ-031 The bench SHALL cover: write 0x12345678 to r0 -> all ports read 0 at r0 and oWriteCount is unchanged.
REQ-032 The bench SHALL cover: write r31=0x00400004 (a jal PC+4) and read r31 on both ports -> both read 0x00400004 and oWriteCount increments by 1.
REQ-033 The bench SHALL cover: assert reset together with a write of 0xFFFFFFFF to r5 -> next cycle r5 reads 0 and oWriteCount=0.
REQ-034 The bench SHALL cover: 65536 committed writes -> oWriteCount returns to 0 and the register contents equal the last value written to each index.
